adc_frame_packer: RTL and testbench
===================================

Name: adc_frame_packer

Overview:
- Sits directly downstream of the row readout sequencer. It consumes the per-ADC data-valid strobe and the ADC output samples, which share that ADC's output clock domain.
- Packs 2 samples per 32-bit word into the host FIFO.
- Frames each readout with a header word and a trailer word.
- Checks that every LB/RB burst delivers the programmed sample count.
- One instance per ADC channel.

Parameters:
- ADC_W, 14, ADC sample width. Legal range 1..16; each sample is zero-extended to 16 bits.
- HDR_MAGIC, 16'hA5A5, upper half of the header word.
- TRL_MAGIC, 16'h5A5A, upper half of the trailer word.

Ports:
- CLK  in  1  ADC output clock (adcN_out_clk).
- rst  in  1  Asynchronous, active-high reset.
- frame_arm  in  1  One-cycle pulse that starts a frame. Driven from the rising edge of re_busy, synchronised upstream.
- dat_valid  in  1  adcN_dat_valid from the readout sequencer.
- adc_dat  in  ADC_W  ADC sample, qualified by dat_valid.
- SAMP_PER_BURST  in  16  Expected samples per contiguous dat_valid burst.
- NUM_BURST  in  16  Bursts per frame, equal to 2*NUM_ROW (LB+RB).
- clr_err  in  1  Clears the sticky error flags.
- fifo_full  in  1  Host FIFO full.
- fifo_wr  out  1  FIFO write strobe.
- fifo_din  out  32  FIFO write data.
- busy  out  1  High from frame_arm acceptance until the trailer is written.
- frame_done  out  1  One-cycle pulse in the cycle the trailer is written.
- len_err  out  1  Sticky: a burst had the wrong length.
- ovf  out  1  Sticky: a word was dropped because fifo_full was high.
- burst_cnt  out  16  Bursts completed in the current frame.

Behaviour:
- Reset values: all outputs 0. State=IDLE; frame_id, pending half-word and all counters are 0. Reset asserted mid-frame abandons the frame with no trailer.
- States: IDLE, HDR, RUN, TRL.
- IDLE:
  - dat_valid is ignored.
  - frame_arm moves to HDR and sets busy.
  - frame_arm in any other state is ignored.
- HDR (1 cycle):
  - Writes {HDR_MAGIC, frame_id}.
  - Clears burst_cnt, sample count and pending half.
  - Goes to RUN, or to TRL if NUM_BURST==0.
- RUN, sample capture:
  - Each cycle with dat_valid=1 captures {zero-extend(adc_dat)} and increments the sample count.
  - 1st sample of a pair is held in the pending low half [15:0].
  - 2nd sample forms {s2, s1}, written with fifo_wr registered one cycle after the 2nd sample's capture cycle.
- RUN, burst end (dat_valid=0 while the previous cycle's dat_valid=1):
  - If a half is pending, write {16'h0, s1} on the next cycle.
  - If sample count != SAMP_PER_BURST, set len_err. Overlong bursts are still fully packed.
  - Increment burst_cnt and clear the sample count.
  - If the new burst_cnt == NUM_BURST, go to TRL.
- TRL (1 cycle, always after any pad/pair write has issued):
  - Writes {TRL_MAGIC, 14'b0, ovf, len_err}, using flag values including events of this frame.
  - Pulses frame_done, clears busy, increments frame_id (mod 2^16), returns to IDLE.
- Write arbitration: at most one FIFO write per cycle by construction. A pair write and a pad write occur on distinct cycles, and the trailer is sequenced after them.
- No backpressure (the ADC cannot stall). Any write attempted while fifo_full=1 is suppressed (fifo_wr=0) and sets ovf. Counting and state progress are unaffected.
- clr_err clears len_err and ovf. If a set event occurs in the same cycle, the set wins.
- All counters are 16-bit unsigned. burst_cnt cannot exceed NUM_BURST within a frame. NUM_BURST/SAMP_PER_BURST are sampled live and must be static while busy.

Decomposition:
- Shared package:
  - State encoding.
  - HDR_MAGIC/TRL_MAGIC defaults.
  - Trailer flag bit positions (bit0 len_err, bit1 ovf).
- One natural sub-module, adc_pair_packer:
  - Holds the pending half and emits pair/pad words plus a word-valid strobe.
  - The top level keeps the FSM, counters, flags and FIFO gating.

Test Plan:
- Basic frame: NUM_BURST=2, SAMP_PER_BURST=4, two bursts of samples 1..4 and 5..8, fifo_full=0.
  - Expected FIFO: A5A5_0000, 0002_0001, 0004_0003, 0006_0005, 0008_0007, 5A5A_0000.
  - frame_done is one pulse on the trailer cycle; busy then falls.
- Odd burst: SAMP_PER_BURST=3, NUM_BURST=1, samples 9,10,11.
  - Expected words: 000A_0009, then pad 0000_000B the cycle after the falling edge.
  - Trailer 5A5A_0000.
- Length error: SAMP_PER_BURST=4, burst of 5 samples.
  - All 3 data words are written (last padded).
  - len_err=1 and the trailer low bits are 01.
  - clr_err then clears len_err. clr_err asserted together with a new error leaves it 1.
- Overflow: hold fifo_full=1 during the 2nd pair write of the basic frame.
  - That word is dropped and ovf=1.
  - Trailer 5A5A_0002 is still written when fifo_full=0.
- Edge cases:
  - NUM_BURST=0 gives header then trailer on consecutive cycles.
  - frame_arm while busy is ignored.
  - dat_valid pulses in IDLE produce no writes.
  - A second frame's header carries frame_id 0001.
- Reset mid-RUN: all outputs return to 0 immediately (asynchronous), with no trailer. The next frame_arm emits header A5A5_0000.

Source files
------------

// File: rtl/adc_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_packer_pkg
// Brief    : Shared state encoding, frame magic defaults and trailer flag
//            layout for the per-channel ADC frame packer.
// Revision : 1.0 - initial release
// ============================================================================
package adc_frame_packer_pkg;

    // Frame sequencer state encoding
    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HDR   = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_TRL   = 2'd3;

    // Each FIFO word carries two 16-bit half-words
    localparam int c_HALF_W = 16;

    // Default upper halves of the header and trailer words
    localparam logic [15:0] c_HDR_MAGIC_DEF = 16'hA5A5;
    localparam logic [15:0] c_TRL_MAGIC_DEF = 16'h5A5A;

    // Flag positions in the low half of the trailer word
    localparam int c_FLAG_LEN_BIT = 0;
    localparam int c_FLAG_OVF_BIT = 1;

    // Assemble a trailer word from its magic and the two sticky flags
    function automatic logic [31:0] trailer_word(input logic [15:0] magic,
                                                 input logic        ovf_f,
                                                 input logic        len_f);
        logic [15:0] flags;
        flags                 = '0;
        flags[c_FLAG_LEN_BIT] = len_f;
        flags[c_FLAG_OVF_BIT] = ovf_f;
        return {magic, flags};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_packer_pair.sv
`default_nettype none
// ============================================================================
// Module   : adc_pair_packer
// Brief    : Holds the first sample of a pair and emits either a full pair
//            word {s2, s1} or, at burst end, a padded word {16'h0, s1}.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pair_packer
    import adc_frame_packer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  capture,
    input  logic                  burst_end,
    input  logic [c_HALF_W-1:0]   samp,
    output logic                  word_vld,
    output logic [2*c_HALF_W-1:0] word
);

    logic                r_pend_vld;
    logic [c_HALF_W-1:0] r_pend;

    // Pending low half: filled by the 1st sample, emptied by the 2nd or by burst end
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
        end else if (clear || burst_end) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
        end else if (capture) begin
            r_pend_vld <= ~r_pend_vld;
            r_pend     <= r_pend_vld ? '0 : samp;
        end
    end

    // A word leaves whenever a half is pending and either a partner arrives or the burst closes
    always_comb begin
        word_vld = r_pend_vld && (capture || burst_end);
        word     = capture ? {samp, r_pend} : {{c_HALF_W{1'b0}}, r_pend};
    end

endmodule
`default_nettype wire

// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_packer
// Brief    : Per-ADC-channel frame packer. Frames each readout with header and
//            trailer words, packs two samples per 32-bit FIFO word, checks
//            burst lengths and flags dropped words.
// Revision : 1.0 - initial release
// ============================================================================
module adc_frame_packer
    import adc_frame_packer_pkg::*;
#(
    parameter int          ADC_W     = 14,
    parameter logic [15:0] HDR_MAGIC = c_HDR_MAGIC_DEF,
    parameter logic [15:0] TRL_MAGIC = c_TRL_MAGIC_DEF
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             frame_arm,
    input  logic             dat_valid,
    input  logic [ADC_W-1:0] adc_dat,
    input  logic [15:0]      SAMP_PER_BURST,
    input  logic [15:0]      NUM_BURST,
    input  logic             clr_err,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [31:0]      fifo_din,
    output logic             busy,
    output logic             frame_done,
    output logic             len_err,
    output logic             ovf,
    output logic [15:0]      burst_cnt
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;

    logic        r_prev_vld;
    logic [15:0] r_samp_cnt;
    logic [15:0] r_burst_cnt;
    logic [15:0] r_frame_id;
    logic        r_wr_req;
    logic [31:0] r_din;
    logic        r_done;
    logic        r_len_err;
    logic        r_ovf;

    logic        w_hdr;
    logic        w_trl;
    logic        w_in_run;
    logic        w_capture;
    logic        w_burst_end;
    logic [15:0] w_burst_cnt_inc;
    logic        w_last_burst;
    logic [15:0] w_samp16;
    logic        w_pair_vld;
    logic [31:0] w_pair_word;
    logic        w_len_nxt;
    logic        w_ovf_nxt;
    logic        w_wr_req_nxt;
    logic [31:0] w_din_nxt;

    assign w_hdr           = (r_state == c_ST_HDR);
    assign w_trl           = (r_state == c_ST_TRL);
    assign w_in_run        = (r_state == c_ST_RUN);
    assign w_capture       = w_in_run && dat_valid;
    assign w_burst_end     = w_in_run && !dat_valid && r_prev_vld;
    assign w_burst_cnt_inc = r_burst_cnt + 16'd1;
    assign w_last_burst    = (w_burst_cnt_inc == NUM_BURST);

    // Sticky flags: a set event in the same cycle as clr_err wins
    assign w_len_nxt = (w_burst_end && (r_samp_cnt != SAMP_PER_BURST)) || (r_len_err && !clr_err);
    assign w_ovf_nxt = (r_wr_req && fifo_full) || (r_ovf && !clr_err);

    // Zero-extend the sample to a 16-bit half-word
    always_comb begin
        w_samp16              = '0;
        w_samp16[ADC_W-1:0]   = adc_dat;
    end

    adc_pair_packer u_pair (
        .CLK       (CLK),
        .rst       (rst),
        .clear     (w_hdr),
        .capture   (w_capture),
        .burst_end (w_burst_end),
        .samp      (w_samp16),
        .word_vld  (w_pair_vld),
        .word      (w_pair_word)
    );

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; frame_arm is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (frame_arm) w_state_nxt = c_ST_HDR;
            c_ST_HDR:  w_state_nxt = (NUM_BURST == 16'd0) ? c_ST_TRL : c_ST_RUN;
            c_ST_RUN:  if (w_burst_end && w_last_burst) w_state_nxt = c_ST_TRL;
            c_ST_TRL:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Write selection; header, pair/pad and trailer never coincide by sequencing
    always_comb begin
        w_wr_req_nxt = w_hdr || w_trl || w_pair_vld;
        if (w_hdr)      w_din_nxt = {HDR_MAGIC, r_frame_id};
        else if (w_trl) w_din_nxt = trailer_word(TRL_MAGIC, w_ovf_nxt, w_len_nxt);
        else            w_din_nxt = w_pair_word;
    end

    // Registered FIFO request, data and frame_done pulse
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_req <= 1'b0;
            r_din    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_wr_req <= w_wr_req_nxt;
            r_din    <= w_din_nxt;
            r_done   <= w_trl;
        end
    end

    // Sample, burst and frame counters plus burst-edge tracking
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_prev_vld  <= 1'b0;
            r_samp_cnt  <= '0;
            r_burst_cnt <= '0;
            r_frame_id  <= '0;
        end else begin
            r_prev_vld <= w_capture;
            if (w_hdr) begin
                r_samp_cnt  <= '0;
                r_burst_cnt <= '0;
            end else if (w_capture) begin
                r_samp_cnt  <= r_samp_cnt + 16'd1;
            end else if (w_burst_end) begin
                r_samp_cnt  <= '0;
                r_burst_cnt <= w_burst_cnt_inc;
            end
            if (w_trl) r_frame_id <= r_frame_id + 16'd1;
        end
    end

    // Sticky error flags
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_len_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_len_err <= w_len_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // A write that meets a full FIFO is dropped here and recorded in ovf
    assign fifo_wr    = r_wr_req && !fifo_full;
    assign fifo_din   = r_din;
    assign busy       = (r_state != c_ST_IDLE);
    assign frame_done = r_done;
    assign len_err    = r_len_err;
    assign ovf        = r_ovf;
    assign burst_cnt  = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_frame_packer
// Brief    : Self-checking bench for adc_frame_packer with directed frames and
//            randomized frames checked against a word-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_frame_packer;

    localparam int ADC_W = 14;

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             frame_arm = 1'b0;
    logic             dat_valid = 1'b0;
    logic [ADC_W-1:0] adc_dat = '0;
    logic [15:0]      SAMP_PER_BURST = '0;
    logic [15:0]      NUM_BURST = '0;
    logic             clr_err = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_wr;
    logic [31:0]      fifo_din;
    logic             busy;
    logic             frame_done;
    logic             len_err;
    logic             ovf;
    logic [15:0]      burst_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_t = 0;
    int full_left = 0;

    logic [31:0] got_w[$];
    int          got_t[$];
    logic [31:0] exp_w[$];
    int          g_lens[$];
    logic [15:0] g_samp[$];

    // Reference-model sticky state
    logic        m_len = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_id  = '0;

    adc_frame_packer #(.ADC_W(ADC_W)) dut (
        .CLK            (CLK),
        .rst            (rst),
        .frame_arm      (frame_arm),
        .dat_valid      (dat_valid),
        .adc_dat        (adc_dat),
        .SAMP_PER_BURST (SAMP_PER_BURST),
        .NUM_BURST      (NUM_BURST),
        .clr_err        (clr_err),
        .fifo_full      (fifo_full),
        .fifo_wr        (fifo_wr),
        .fifo_din       (fifo_din),
        .busy           (busy),
        .frame_done     (frame_done),
        .len_err        (len_err),
        .ovf            (ovf),
        .burst_cnt      (burst_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // FIFO monitor sampled on the inactive edge
    always @(negedge CLK) begin
        if (fifo_wr) begin
            got_w.push_back(fifo_din);
            got_t.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_t   = cyc;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (full_left > 0) begin
            full_left--;
            if (full_left == 0) fifo_full = 1'b0;
        end
    endtask

    task automatic clear_logs();
        got_w.delete();
        got_t.delete();
        exp_w.delete();
    endtask

    // Expected word list for one frame, built from the burst list
    task automatic model_frame(input int nb, input int spb);
        int idx;
        idx = 0;
        exp_w.push_back({16'hA5A5, m_id});
        for (int b = 0; b < nb; b++) begin
            if (g_lens[b] != spb) m_len = 1'b1;
            for (int i = 0; i < g_lens[b]; i += 2) begin
                if (i + 1 < g_lens[b]) exp_w.push_back({g_samp[idx+i+1], g_samp[idx+i]});
                else                   exp_w.push_back({16'h0000, g_samp[idx+i]});
            end
            idx += g_lens[b];
        end
        exp_w.push_back({16'h5A5A, 14'h0, m_ovf, m_len});
        m_id = m_id + 16'd1;
    endtask

    // mode 1: frame_arm pulse after first burst; mode 2: clr_err on the last burst-end cycle
    task automatic drive_frame(input int nb, input int spb, input int full_idx, input int mode);
        int idx;
        int d0;
        int lim;
        idx = 0;
        d0  = done_cnt;
        SAMP_PER_BURST = spb[15:0];
        NUM_BURST      = nb[15:0];
        frame_arm = 1'b1;
        tick();
        frame_arm = 1'b0;
        tick();
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < g_lens[b]; i++) begin
                dat_valid = 1'b1;
                adc_dat   = g_samp[idx][ADC_W-1:0];
                if (idx == full_idx) begin
                    fifo_full = 1'b1;
                    full_left = 2;
                end
                idx++;
                tick();
            end
            dat_valid = 1'b0;
            adc_dat   = '0;
            if (mode == 1 && b == 0)      frame_arm = 1'b1;
            if (mode == 2 && b == nb - 1) clr_err   = 1'b1;
            tick();
            frame_arm = 1'b0;
            clr_err   = 1'b0;
            tick();
        end
        lim = 0;
        while (done_cnt == d0 && lim < 100) begin
            tick();
            lim++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL frame_done_timeout got none want a pulse within 100 cycles");
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({fifo_wr, fifo_din, busy, frame_done, len_err, ovf, burst_cnt} !== 52'h0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b din=%h busy=%b done=%b len=%b ovf=%b bc=%0d want all 0",
                     fifo_wr, fifo_din, busy, frame_done, len_err, ovf, burst_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        clear_logs();
        g_lens = '{4, 4};
        g_samp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_w  = '{32'hA5A5_0000, 32'h0002_0001, 32'h0004_0003, 32'h0006_0005,
                   32'h0008_0007, 32'h5A5A_0000};
        d0 = done_cnt;
        drive_frame(2, 4, -1, 0);
        m_id = m_id + 16'd1;
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || got_t.size() == 0 || done_t != got_t[got_t.size()-1]) begin
            errors++;
            $display("FAIL basic_done_pulse got %0d pulses at cycle %0d want 1 on trailer cycle", done_cnt - d0, done_t);
        end
        checks++;
        if (busy !== 1'b0 || burst_cnt !== 16'd2 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got busy=%b bc=%0d len=%b want busy=0 bc=2 len=0", busy, burst_cnt, len_err);
        end
    endtask

    task automatic test_odd();
        clear_logs();
        g_lens = '{3};
        g_samp = '{16'd9, 16'd10, 16'd11};
        exp_w  = '{32'hA5A5_0001, 32'h000A_0009, 32'h0000_000B, 32'h5A5A_0000};
        drive_frame(1, 3, -1, 0);
        m_id = m_id + 16'd1;
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL odd_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL odd_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        if (got_t.size() == 4) begin
            checks++;
            if (got_t[2] - got_t[1] != 2 || got_t[3] - got_t[2] != 1) begin
                errors++;
                $display("FAIL odd_timing got pad gap %0d trl gap %0d want 2 and 1",
                         got_t[2] - got_t[1], got_t[3] - got_t[2]);
            end
        end
    endtask

    task automatic test_len_err();
        logic [31:0] last;
        clear_logs();
        g_lens = '{5};
        g_samp.delete();
        for (int i = 0; i < 5; i++) g_samp.push_back(16'($urandom_range(0, (1 << ADC_W) - 1)));
        model_frame(1, 4);
        drive_frame(1, 4, -1, 0);
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL len_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL len_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        last = (got_w.size() > 0) ? got_w[got_w.size()-1] : 32'h0;
        checks++;
        if (last[1:0] !== 2'b01 || len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_flag got trl_bits=%b len_err=%b want 01 and 1", last[1:0], len_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_len = 1'b0;
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_clear got %b want 0", len_err);
        end
        clear_logs();
        g_lens = '{2};
        g_samp = '{16'h0011, 16'h0022};
        model_frame(1, 4);
        drive_frame(1, 4, -1, 2);
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_set_wins got %b want 1", len_err);
        end
        checks++;
        if (got_w.size() != 3 || got_w[2] !== exp_w[2]) begin
            errors++;
            $display("FAIL len_set_wins_trailer got %0d words last %h want %h",
                     got_w.size(), (got_w.size() > 0) ? got_w[got_w.size()-1] : 32'h0, exp_w[2]);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_len = 1'b0;
    endtask

    task automatic test_ovf();
        clear_logs();
        g_lens = '{4, 4};
        g_samp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_w  = '{{16'hA5A5, m_id}, 32'h0002_0001, 32'h0006_0005, 32'h0008_0007, 32'h5A5A_0002};
        drive_frame(2, 4, 3, 0);
        m_id = m_id + 16'd1;
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL ovf_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL ovf_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b want 1", ovf);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", ovf);
        end
    endtask

    task automatic test_edges();
        // Zero-burst frame: header then trailer back to back
        clear_logs();
        g_lens.delete();
        g_samp.delete();
        model_frame(0, 4);
        drive_frame(0, 4, -1, 0);
        checks++;
        if (got_w.size() != 2 || got_w[0] !== exp_w[0] || got_w[1] !== exp_w[1] || got_t[1] - got_t[0] != 1) begin
            errors++;
            $display("FAIL nb0_frame got %0d words want %h,%h on consecutive cycles",
                     got_w.size(), exp_w[0], exp_w[1]);
        end
        // dat_valid activity in IDLE is ignored
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            dat_valid = 1'b1;
            adc_dat   = ADC_W'($urandom);
            tick();
        end
        dat_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (got_w.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got %0d writes busy=%b want 0 writes busy=0", got_w.size(), busy);
        end
        // frame_arm while busy is ignored
        clear_logs();
        g_lens = '{4, 4};
        g_samp.delete();
        for (int i = 0; i < 8; i++) g_samp.push_back(16'($urandom_range(0, (1 << ADC_W) - 1)));
        model_frame(2, 4);
        drive_frame(2, 4, -1, 1);
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL arm_busy_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL arm_busy_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        int nb;
        int spb;
        int tot;
        for (int f = 0; f < 6; f++) begin
            clear_logs();
            nb  = $urandom_range(1, 4);
            spb = $urandom_range(1, 6);
            g_lens.delete();
            g_samp.delete();
            tot = 0;
            for (int b = 0; b < nb; b++) begin
                g_lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : spb);
                tot += g_lens[b];
            end
            for (int i = 0; i < tot; i++) g_samp.push_back(16'($urandom_range(0, (1 << ADC_W) - 1)));
            model_frame(nb, spb);
            drive_frame(nb, spb, -1, 0);
            checks++;
            if (got_w.size() != exp_w.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", f, got_w.size(), exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word[%0d] got %h want %h", f, i, got_w[i], exp_w[i]);
                end
            end
            checks++;
            if (len_err !== m_len || burst_cnt !== nb[15:0]) begin
                errors++;
                $display("FAIL rand%0d_status got len=%b bc=%0d want len=%b bc=%0d", f, len_err, burst_cnt, m_len, nb);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        SAMP_PER_BURST = 16'd4;
        NUM_BURST      = 16'd2;
        frame_arm = 1'b1;
        tick();
        frame_arm = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            dat_valid = 1'b1;
            adc_dat   = ADC_W'(i + 1);
            tick();
        end
        dat_valid = 1'b0;
        tick();
        tick();
        dat_valid = 1'b1;
        adc_dat   = ADC_W'(7);
        tick();
        checks++;
        if (busy !== 1'b1 || burst_cnt !== 16'd1 || len_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got busy=%b bc=%0d len=%b want 1,1,1", busy, burst_cnt, len_err);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_wr, fifo_din, busy, frame_done, len_err, ovf, burst_cnt} !== 52'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got wr=%b din=%h busy=%b done=%b len=%b ovf=%b bc=%0d want all 0",
                     fifo_wr, fifo_din, busy, frame_done, len_err, ovf, burst_cnt);
        end
        clear_logs();
        dat_valid = 1'b0;
        tick();
        rst = 1'b0;
        m_id  = '0;
        m_len = 1'b0;
        m_ovf = 1'b0;
        tick();
        tick();
        checks++;
        if (got_w.size() != 0) begin
            errors++;
            $display("FAIL mid_no_trailer got %0d writes first %h want 0", got_w.size(), got_w[0]);
        end
        clear_logs();
        g_lens = '{2};
        g_samp = '{16'h0123, 16'h0456};
        model_frame(1, 2);
        drive_frame(1, 2, -1, 0);
        checks++;
        if (got_w.size() == 0 || got_w[0] !== 32'hA5A5_0000) begin
            errors++;
            $display("FAIL mid_next_header got %h want a5a50000", (got_w.size() > 0) ? got_w[0] : 32'h0);
        end
        checks++;
        if (got_w.size() != exp_w.size() || got_w[got_w.size()-1] !== exp_w[exp_w.size()-1]) begin
            errors++;
            $display("FAIL mid_next_frame got %0d words want %0d", got_w.size(), exp_w.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_len_err();
        test_ovf();
        test_edges();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
